// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes on both sides.
// SLL is done iteratively, one bit per cycle; every other operation completes in one cycle.
module alu_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         aluop,
    input  logic [5:0]         funct,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               lt,
    output logic               illegal
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_SLL, OP_MOVE, OP_NAND, OP_OR} op_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               lt_q, lt_d;
    logic               illegal_q, illegal_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;

    op_t                op;
    logic               op_illegal;
    logic [WIDTH-1:0]   alu_out;
    logic [WIDTH-1:0]   shifted;
    logic [SHAMT_W-1:0] shamt;

    assign shamt   = b[SHAMT_W-1:0];
    assign shifted = {result_q[WIDTH-2:0], 1'b0};

    always_comb begin
        op         = OP_ADD;
        op_illegal = 1'b0;
        case (aluop)
            2'b00: op = OP_ADD;
            2'b01: op = OP_SUB;
            2'b10: begin
                case (funct)
                    6'd1:    op = OP_SLL;
                    6'd2:    op = OP_MOVE;
                    6'd3:    op = OP_NAND;
                    6'd4:    op = OP_OR;
                    6'd5:    op = OP_ADD;
                    default: op_illegal = 1'b1;
                endcase
            end
            default: op_illegal = 1'b1;
        endcase
    end

    // SLL yields a here; only a zero count finishes it without entering SHIFT
    always_comb begin
        alu_out = a + b;
        case (op)
            OP_SUB:  alu_out = a - b;
            OP_SLL:  alu_out = a;
            OP_MOVE: alu_out = a;
            OP_NAND: alu_out = ~(a & b);
            OP_OR:   alu_out = a | b;
            default: alu_out = a + b;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        lt_d      = lt_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (op == OP_SLL && shamt != '0) begin
                        result_d  = a;
                        cnt_d     = shamt;
                        zero_d    = 1'b0;
                        lt_d      = 1'b0;
                        illegal_d = 1'b0;
                        state_d   = SHIFT;
                    end else begin
                        result_d  = alu_out;
                        zero_d    = (alu_out == '0);
                        lt_d      = (op == OP_SUB) && ($signed(a) < $signed(b));
                        illegal_d = op_illegal;
                        state_d   = DONE;
                    end
                end
            end
            SHIFT: begin
                result_d = shifted;
                cnt_d    = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    zero_d  = (shifted == '0);
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            lt_q      <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            lt_q      <= lt_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    assign result  = result_q;
    assign zero    = zero_q;
    assign lt      = lt_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed corner cases plus random operations
// compared against a behavioural reference model.
module tb_alu_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        lt;
    logic        illegal;

    int n_cmp = 0;
    int n_err = 0;

    alu_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluop     (aluop),
        .funct     (funct),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .lt        (lt),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: result, lt, illegal and cycles from acceptance to out_valid.
    function automatic void model(input logic [1:0] op, input logic [5:0] fn,
                                  input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic l,
                                  output logic il, output int lat);
        longint sx;
        longint sy;
        logic [4:0] n;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        n   = y[4:0];
        r   = x + y;
        l   = 1'b0;
        il  = 1'b0;
        lat = 1;
        if (op == 2'b01) begin
            r = x - y;
            l = (sx < sy);
        end else if (op == 2'b10) begin
            case (fn)
                6'd1: begin r = x << n; lat = 1 + int'(n); end
                6'd2: r = x;
                6'd3: r = ~(x & y);
                6'd4: r = x | y;
                6'd5: r = x + y;
                default: il = 1'b1;
            endcase
        end else if (op == 2'b11) begin
            il = 1'b1;
        end
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [5:0] fn,
                          input logic [31:0] x, input logic [31:0] y,
                          input int hold, input string tag);
        logic [31:0] er;
        logic        el;
        logic        eil;
        int          elat;
        int          lat;
        int          guard;
        logic        busy_bad;
        logic        hold_bad;
        model(op, fn, x, y, er, el, eil, elat);
        guard = 0;
        while (in_ready !== 1'b1 && guard < 100) begin
            tick;
            guard++;
        end
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        aluop     = op;
        funct     = fn;
        a         = x;
        b         = y;
        out_ready = 1'b0;
        tick;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        lat      = 1;
        busy_bad = 1'b0;
        while (out_valid !== 1'b1 && lat < 100) begin
            if (in_ready !== 1'b0) busy_bad = 1'b1;
            in_valid = 1'($urandom_range(0, 1));
            tick;
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(elat));
        check({tag, "_busy_ready"}, 64'(busy_bad), 64'd0);
        check({tag, "_result"}, 64'(result), 64'(er));
        check({tag, "_zero"}, 64'(zero), 64'(er == 32'd0));
        check({tag, "_lt"}, 64'(lt), 64'(el));
        check({tag, "_illegal"}, 64'(illegal), 64'(eil));
        hold_bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            aluop    = 2'($urandom);
            a        = $urandom;
            tick;
            if (result !== er || out_valid !== 1'b1 || in_ready !== 1'b0 ||
                zero !== (er == 32'd0) || lt !== el || illegal !== eil)
                hold_bad = 1'b1;
        end
        if (hold > 0) check({tag, "_hold_stable"}, 64'(hold_bad), 64'd0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        tick;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check({tag, "_back_idle"}, {62'd0, out_valid, in_ready}, 64'b01);
    endtask

    initial begin
        logic [1:0]  rop;
        logic [5:0]  rfn;
        logic [31:0] rb;
        int          seen;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        aluop     = '0;
        funct     = '0;
        a         = '0;
        b         = '0;
        tick;
        tick;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_flags", {61'd0, zero, lt, illegal}, 64'd0);
        rst_n = 1'b1;
        tick;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        run_op(2'b00, 6'd0, 32'd7, 32'd5, 0, "add_7_5");
        run_op(2'b01, 6'd0, 32'hFFFF_FFFD, 32'd2, 0, "sub_neg");
        run_op(2'b01, 6'd0, 32'd4, 32'd4, 0, "sub_eq");
        run_op(2'b01, 6'd0, 32'h7FFF_FFFF, 32'h8000_0000, 0, "sub_wrap_lt");
        run_op(2'b10, 6'd1, 32'd1, 32'd31, 0, "sll_31");
        run_op(2'b10, 6'd1, 32'h0000_ABCD, 32'd0, 0, "sll_0");
        run_op(2'b10, 6'd1, 32'h0000_0003, 32'hFFFF_FFE3, 0, "sll_hi_b");
        run_op(2'b10, 6'd1, 32'h0000_0100, 32'd24, 0, "sll_to_zero");
        run_op(2'b10, 6'd2, 32'h1234_5678, 32'h9, 0, "move");
        run_op(2'b10, 6'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "nand");
        run_op(2'b10, 6'd4, 32'hF0F0_0000, 32'h0000_0F0F, 0, "or");
        run_op(2'b10, 6'd5, 32'd10, 32'd20, 0, "radd");
        run_op(2'b10, 6'd9, 32'd2, 32'd3, 0, "funct_illegal");
        run_op(2'b11, 6'd1, 32'd6, 32'd7, 0, "aluop_illegal");
        run_op(2'b00, 6'd0, 32'hFFFF_FFFF, 32'd1, 0, "add_wrap");
        run_op(2'b00, 6'd0, 32'd100, 32'd23, 5, "hold5");

        // Reset in the middle of a 20-step shift
        in_valid = 1'b1;
        aluop    = 2'b10;
        funct    = 6'd1;
        a        = 32'h0000_0001;
        b        = 32'd20;
        tick;
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_result", 64'(result), 64'd0);
        check("midrst_flags", {61'd0, zero, lt, illegal}, 64'd0);
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        seen      = 0;
        for (int i = 0; i < 30; i++) begin
            tick;
            if (out_valid === 1'b1) seen++;
        end
        check("midrst_no_stale", 64'(seen), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);

        // Reset wins over a simultaneous request
        rst_n    = 1'b0;
        in_valid = 1'b1;
        aluop    = 2'b00;
        a        = 32'd1;
        b        = 32'd1;
        tick;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        tick;
        check("rst_prio_no_accept", {62'd0, out_valid, in_ready}, 64'b01);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom);
            rfn = 6'($urandom_range(0, 8));
            rb  = $urandom;
            if (i % 4 == 0) begin
                rop = 2'b10;
                rfn = 6'd1;
            end
            run_op(rop, rfn, $urandom, rb, int'($urandom_range(0, 3)), $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
